// File: rtl/dmem_mmio_bus.sv
// Data-side memory for the single-cycle core: word RAM plus a 16-byte MMIO window
// holding a TX FIFO with a valid/ready port, a free-running timer and sticky status flags.
module dmem_mmio_bus #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int          AW       = $clog2(RAM_WORDS);
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [31:0] RAM_END  = 32'(RAM_WORDS * 4);
    localparam logic [31:0] MMIO_END = MMIO_BASE + 32'd16;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_TIMER  = 2'd2,
        REG_CTRL   = 2'd3
    } mmio_reg_e;

    logic [31:0]   ram  [RAM_WORDS];
    logic [31:0]   fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   timer;
    logic [1:0]    ctrl;
    logic          drop_flag, wrap_flag, unmap_flag;

    logic          is_ram, is_mmio, wr_mmio;
    mmio_reg_e     reg_sel;
    logic          push, pop, accept, drop, full;
    logic          st_clr, tim_wr, ctrl_wr, unmap_wr, tim_wrap;
    logic [31:0]   status;

    // Full-width compares keep the decode exact; boundaries are word aligned.
    assign is_ram   = a < RAM_END;
    assign is_mmio  = (a >= MMIO_BASE) && (a < MMIO_END);
    assign reg_sel  = mmio_reg_e'(a[3:2] - MMIO_BASE[3:2]);
    assign wr_mmio  = we & is_mmio;

    assign push     = wr_mmio & (reg_sel == REG_TXDATA);
    assign st_clr   = wr_mmio & (reg_sel == REG_STATUS);
    assign tim_wr   = wr_mmio & (reg_sel == REG_TIMER);
    assign ctrl_wr  = wr_mmio & (reg_sel == REG_CTRL);
    assign unmap_wr = we & ~is_ram & ~is_mmio;

    assign full     = count == CW'(FIFO_DEPTH);
    assign tx_valid = count != '0;
    assign pop      = tx_valid & tx_ready;
    // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
    assign accept   = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign tim_wrap = ctrl[0] & ~tim_wr & (timer == '1);

    assign tx_data  = tx_valid ? fifo[rd_ptr] : '0;
    assign status   = {16'h0, 8'(count), 3'b000, unmap_flag, wrap_flag, drop_flag, full, ~tx_valid};
    assign irq      = (drop_flag | wrap_flag | unmap_flag) & ctrl[1];

    // NOTE: storage arrays have no reset so they map onto plain RAM; stale FIFO
    // entries are harmless because count gates tx_valid and tx_data.
    always_ff @(posedge clk) begin
        if (we && is_ram) ram[a[AW+1:2]] <= wd;
        if (accept)       fifo[wr_ptr]   <= wd;
    end

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            timer      <= '0;
            ctrl       <= '0;
            drop_flag  <= 1'b0;
            wrap_flag  <= 1'b0;
            unmap_flag <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop)      count <= count + CW'(1);
            else if (pop && !accept) count <= count - CW'(1);

            if (tim_wr)       timer <= wd;
            else if (ctrl[0]) timer <= timer + 32'd1;
            if (ctrl_wr)      ctrl  <= wd[1:0];

            // Setting a flag takes priority over clearing it in the same edge.
            drop_flag  <= drop     | (drop_flag  & ~(st_clr & wd[2]));
            wrap_flag  <= tim_wrap | (wrap_flag  & ~(st_clr & wd[3]));
            unmap_flag <= unmap_wr | (unmap_flag & ~(st_clr & wd[4]));
        end
    end

    // NOTE: rd gets a default before any branch so no latch is inferred.
    always_comb begin
        rd = '0;
        if (is_ram) begin
            rd = ram[a[AW+1:2]];
        end else if (is_mmio) begin
            case (reg_sel)
                REG_STATUS: rd = status;
                REG_TIMER:  rd = timer;
                REG_CTRL:   rd = {30'b0, ctrl};
                default:    rd = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio_bus.sv
// Directed self-checking bench for dmem_mmio_bus: RAM, FIFO flow control,
// timer wrap, sticky flags, unmapped writes and asynchronous reset.
module tb_dmem_mmio_bus;
    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        irq;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] TXDATA = 32'h100;
    localparam logic [31:0] STATUS = 32'h104;
    localparam logic [31:0] TIMER  = 32'h108;
    localparam logic [31:0] CTRL   = 32'h10C;

    dmem_mmio_bus dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        a  = addr;
        wd = data;
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        a  = addr;
        we = 1'b0;
        #1;
        check(tag, rd, exp);
    endtask

    logic [31:0] drain_exp [4];
    logic [31:0] pp_exp    [4];

    initial begin
        reset = 1'b0; we = 1'b0; a = '0; wd = '0; tx_ready = 1'b0;
        drain_exp = '{32'hA, 32'hB, 32'hC, 32'hD};
        pp_exp    = '{32'h2, 32'h3, 32'h4, 32'h55};
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_irq",      32'(irq),      32'h0);
        check("rst_tx_data",  tx_data,       32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // RAM and idle status
        rd_chk("status_idle", STATUS, 32'h0000_0001);
        wr(32'h64, 32'h7);
        rd_chk("ram_64", 32'h64, 32'h7);
        rd_chk("txdata_read", TXDATA, 32'h0);
        rd_chk("timer_idle", TIMER, 32'h0);

        // FIFO fill, no fall-through, overflow
        a = TXDATA; wd = 32'hA; we = 1'b1;
        #1;
        check("no_fallthrough", 32'(tx_valid), 32'h0);
        step();
        we = 1'b0;
        check("first_push_valid", 32'(tx_valid), 32'h1);
        check("first_push_data",  tx_data,       32'hA);
        wr(TXDATA, 32'hB);
        wr(TXDATA, 32'hC);
        rd_chk("status_cnt3", STATUS, 32'h0000_0300);
        wr(TXDATA, 32'hD);
        wr(TXDATA, 32'hE);
        rd_chk("status_overflow", STATUS, 32'h0000_0406);
        check("head_after_fill", tx_data, 32'hA);
        wr(STATUS, 32'h4);
        rd_chk("status_drop_w1c", STATUS, 32'h0000_0402);

        // Drain with backpressure: one ready cycle in three
        for (int k = 0; k < 4; k++) begin
            repeat (2) begin
                step();
                check("stall_data", tx_data, drain_exp[k]);
            end
            check("stall_valid", 32'(tx_valid), 32'h1);
            tx_ready = 1'b1;
            step();
            tx_ready = 1'b0;
        end
        check("drained_valid", 32'(tx_valid), 32'h0);
        check("drained_data",  tx_data,       32'h0);
        rd_chk("drained_status", STATUS, 32'h0000_0001);

        // Push and pop together while full
        wr(TXDATA, 32'h1);
        wr(TXDATA, 32'h2);
        wr(TXDATA, 32'h3);
        wr(TXDATA, 32'h4);
        rd_chk("refill_status", STATUS, 32'h0000_0402);
        a = TXDATA; wd = 32'h55; we = 1'b1; tx_ready = 1'b1;
        step();
        we = 1'b0; tx_ready = 1'b0;
        rd_chk("pushpop_status", STATUS, 32'h0000_0402);
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("pushpop_order", tx_data, pp_exp[k]);
            step();
        end
        tx_ready = 1'b0;
        check("pushpop_empty", 32'(tx_valid), 32'h0);

        // Timer wrap, irq, write-wins, set-wins-over-W1C
        wr(TIMER, 32'hFFFF_FFFE);
        wr(CTRL, 32'h3);
        rd_chk("timer_fffe", TIMER, 32'hFFFF_FFFE);
        step();
        rd_chk("timer_ffff", TIMER, 32'hFFFF_FFFF);
        step();
        rd_chk("timer_wrap0", TIMER, 32'h0);
        rd_chk("status_wrap", STATUS, 32'h0000_0009);
        check("irq_wrap", 32'(irq), 32'h1);
        wr(TIMER, 32'h1234);
        rd_chk("timer_write_wins", TIMER, 32'h1234);
        step();
        rd_chk("timer_incr", TIMER, 32'h1235);
        wr(STATUS, 32'h8);
        rd_chk("wrap_w1c", STATUS, 32'h0000_0001);
        check("irq_cleared", 32'(irq), 32'h0);
        wr(TIMER, 32'hFFFF_FFFF);
        wr(STATUS, 32'h8);
        rd_chk("set_wins", STATUS, 32'h0000_0009);
        wr(CTRL, 32'h2);
        wr(STATUS, 32'h1C);
        rd_chk("flags_cleared", STATUS, 32'h0000_0001);
        rd_chk("ctrl_read", CTRL, 32'h0000_0002);

        // Unmapped write aliases nothing in RAM
        wr(32'h0, 32'h11);
        wr(32'h200, 32'hDEAD);
        rd_chk("ram0_kept", 32'h0, 32'h11);
        rd_chk("ram64_kept", 32'h64, 32'h7);
        rd_chk("unmapped_read", 32'h200, 32'h0);
        rd_chk("status_unmap", STATUS, 32'h0000_0011);
        check("irq_unmap", 32'(irq), 32'h1);

        // Asynchronous reset between edges with a word in flight
        wr(TXDATA, 32'h77);
        wr(CTRL, 32'h3);
        check("pre_reset_valid", 32'(tx_valid), 32'h1);
        a = STATUS;
        #2;
        reset = 1'b0;
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'h0);
        check("async_irq",      32'(irq),      32'h0);
        check("async_status",   rd,            32'h0000_0001);
        check("async_tx_data",  tx_data,       32'h0);
        rd_chk("async_ctrl", CTRL, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        rd_chk("post_reset_timer", TIMER, 32'h0);
        rd_chk("ram_survives_reset", 32'h64, 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
